// File: rtl/mux_arb_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin mux arbiter.
// Imported by the picker and the arbiter top.
package mux_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot8(input logic [SEL_W-1:0] index);
        logic [NUM_REQ-1:0] vec;
        vec        = '0;
        vec[index] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set request scanning ptr+1 .. ptr+8 (mod 8).
// The pointer position itself is scanned last, so the previous holder only wins when alone.
module rr_pick8
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    // rot_req[k] is the request that sits k+1 places after ptr
    logic [NUM_REQ-1:0] rot_req;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [SEL_W-1:0] pos;
            assign pos         = ptr + SEL_W'(gi + 1);
            assign rot_req[gi] = req[pos];
        end
    endgenerate

    logic [SEL_W-1:0] offset;

    always_comb begin
        offset = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                offset = SEL_W'(i);
            end
        end
    end

    assign found = |req;
    assign idx   = ptr + offset + SEL_W'(1);

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 data mux between eight requesters,
// with a per-grant hold limit that forces rotation and flags it with a timeout pulse.
module mux8_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    input  logic [NUM_REQ-1:0] data_i,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic               valid,
    output logic               timeout,
    output logic               data_o
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t             state_reg;
    logic [SEL_W-1:0]   ptr_reg;
    logic [HOLD_W-1:0]  hold_cnt_reg;

    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic [SEL_W-1:0]   pick_ptr;
    logic               hold_limit;
    logic               release_now;
    logic               timeout_next;

    // On release the picker must already see the updated pointer (the current holder)
    assign pick_ptr = (state_reg == GRANT) ? sel : ptr_reg;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign hold_limit   = (hold_cnt_reg == HOLD_LAST);
    assign release_now  = done || !req[sel] || hold_limit;
    assign timeout_next = hold_limit && !done && req[sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            grant        <= '0;
            sel          <= '0;
            valid        <= 1'b0;
            timeout      <= 1'b0;
            ptr_reg      <= SEL_W'(NUM_REQ - 1);
            hold_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    timeout <= 1'b0;
                    if (pick_found) begin
                        state_reg    <= GRANT;
                        grant        <= onehot8(pick_idx);
                        sel          <= pick_idx;
                        valid        <= 1'b1;
                        hold_cnt_reg <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        ptr_reg <= sel;
                        timeout <= timeout_next;
                        if (pick_found) begin
                            grant        <= onehot8(pick_idx);
                            sel          <= pick_idx;
                            hold_cnt_reg <= '0;
                        end else begin
                            state_reg <= IDLE;
                            grant     <= '0;
                            valid     <= 1'b0;
                        end
                    end else begin
                        timeout      <= 1'b0;
                        hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    grant     <= '0;
                    valid     <= 1'b0;
                    timeout   <= 1'b0;
                end
            endcase
        end
    end

    logic mux_bit;

    always_comb begin
        mux_bit = 1'b0;
        case (sel)
            3'd0: mux_bit = data_i[0];
            3'd1: mux_bit = data_i[1];
            3'd2: mux_bit = data_i[2];
            3'd3: mux_bit = data_i[3];
            3'd4: mux_bit = data_i[4];
            3'd5: mux_bit = data_i[5];
            3'd6: mux_bit = data_i[6];
            3'd7: mux_bit = data_i[7];
            default: mux_bit = 1'b0;
        endcase
    end

    assign data_o = valid & mux_bit;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: two instances (hold limit 16 and 4) share inputs and are
// compared every cycle against a queue-free behavioural model of the arbitration rules.
module tb_mux8_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] data_i;

    logic [7:0] grant_a, grant_b;
    logic [2:0] sel_a, sel_b;
    logic       valid_a, valid_b, timeout_a, timeout_b, data_o_a, data_o_b;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    always #5 clk = ~clk;

    mux8_rr_arbiter #(.MAX_HOLD(16), .HOLD_W(8)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done), .data_i(data_i),
        .grant(grant_a), .sel(sel_a), .valid(valid_a), .timeout(timeout_a), .data_o(data_o_a)
    );

    mux8_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(3)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done), .data_i(data_i),
        .grant(grant_b), .sel(sel_b), .valid(valid_b), .timeout(timeout_b), .data_o(data_o_b)
    );

    // Model state per instance: holder = -1 when idle, cnt = cycles the grant has lasted
    int m_max[2]    = '{16, 4};
    int m_holder[2];
    int m_ptr[2];
    int m_sel[2];
    int m_cnt[2];
    bit m_to[2];

    function automatic bit ref_mux(input logic [7:0] d, input int s);
        return bit'((d >> s) & 8'h01);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_holder[k] = -1; m_ptr[k] = 7; m_sel[k] = 0; m_cnt[k] = 0; m_to[k] = 1'b0;
        end
    endtask

    task automatic model_pick(input int k);
        m_holder[k] = -1;
        for (int j = 1; j <= 8; j++) begin
            int c;
            c = (m_ptr[k] + j) % 8;
            if (req[c] && m_holder[k] < 0) m_holder[k] = c;
        end
        if (m_holder[k] >= 0) begin
            m_sel[k] = m_holder[k];
            m_cnt[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (m_holder[k] < 0) begin
                m_to[k] = 1'b0;
                model_pick(k);
            end else begin
                int  h;
                bit  lim;
                h   = m_holder[k];
                lim = (m_cnt[k] == m_max[k] - 1);
                if (done || !req[h] || lim) begin
                    m_to[k]  = lim && !done && req[h];
                    m_ptr[k] = h;
                    model_pick(k);
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                    m_to[k]  = 1'b0;
                end
            end
        end
    endtask

    function automatic logic [13:0] exp_vec(input int k);
        logic [7:0] g;
        bit         v;
        v = (m_holder[k] >= 0);
        g = v ? (8'h01 << m_holder[k]) : 8'h00;
        return {g, 3'(m_sel[k]), v, m_to[k], v ? ref_mux(data_i, m_sel[k]) : 1'b0};
    endfunction

    function automatic logic [13:0] act_vec(input int k);
        if (k == 0) return {grant_a, sel_a, valid_a, timeout_a, data_o_a};
        return {grant_b, sel_b, valid_b, timeout_b, data_o_b};
    endfunction

    // Advance one clock: inputs already driven, model follows the edge, outputs sampled at negedge
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 8'h00; done = 1'b0; data_i = 8'h00;
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (act_vec(k) !== exp_vec(k) || act_vec(k) !== 14'h0) begin
                    miscompares++;
                    $display("FAIL reset_idle dut%0d cyc %0d: got %h expected %h", k, cyc, act_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_single();
        req = 8'h01; data_i = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            done = (i == 3);
            tick();
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (act_vec(k) !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL single_req dut%0d cyc %0d: got %h expected %h", k, cyc, act_vec(k), exp_vec(k));
                end
            end
        end
        done = 1'b0; req = 8'h00;
        tick();
    endtask

    task automatic test_all_req();
        req = 8'hFF; data_i = $urandom;
        for (int i = 0; i < 24; i++) begin
            done = (m_holder[0] >= 0 && m_cnt[0] == 1);
            tick();
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (act_vec(k) !== exp_vec(k) || (act_vec(k) >> 6) == 14'h0) begin
                    miscompares++;
                    $display("FAIL all_req_rotate dut%0d cyc %0d: got %h expected %h", k, cyc, act_vec(k), exp_vec(k));
                end
            end
        end
        done = 1'b0; req = 8'h00;
        tick();
    endtask

    task automatic test_ptr_wrap();
        req = 8'h20;
        tick();
        for (int i = 0; i < 12; i++) begin
            req  = 8'h90;
            done = (i % 2 == 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (act_vec(k) !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL ptr_wrap dut%0d cyc %0d: got %h expected %h", k, cyc, act_vec(k), exp_vec(k));
                end
            end
        end
        done = 1'b0; req = 8'h00;
        tick();
    endtask

    task automatic test_timeout();
        req = 8'h0C; done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (act_vec(k) !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL hold_timeout dut%0d cyc %0d: got %h expected %h", k, cyc, act_vec(k), exp_vec(k));
                end
            end
        end
        // done landing on the limit cycle: release is a normal one
        for (int i = 0; i < 16; i++) begin
            done = (m_holder[1] >= 0 && m_cnt[1] == 3);
            tick();
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (act_vec(k) !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL done_at_limit dut%0d cyc %0d: got %h expected %h", k, cyc, act_vec(k), exp_vec(k));
                end
            end
        end
        done = 1'b0; req = 8'h00;
        tick();
    endtask

    task automatic test_data_sweep();
        data_i = 8'hA5; req = 8'hFF; done = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 9) req = 8'h00;
            tick();
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (act_vec(k) !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL data_sweep dut%0d cyc %0d: got %h expected %h", k, cyc, act_vec(k), exp_vec(k));
                end
            end
        end
        done = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            req    = 8'($urandom) & 8'($urandom);
            done   = ($urandom_range(0, 3) == 0);
            data_i = 8'($urandom);
            tick();
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (act_vec(k) !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL random dut%0d cyc %0d: got %h expected %h", k, cyc, act_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        req = 8'h40; done = 1'b0; data_i = 8'hFF;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (act_vec(k) !== 14'h0) begin
                miscompares++;
                $display("FAIL reset_mid_grant dut%0d cyc %0d: got %h expected %h", k, cyc, act_vec(k), 14'h0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1; req = 8'h00;
        tick();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (act_vec(k) !== exp_vec(k)) begin
                miscompares++;
                $display("FAIL after_reset dut%0d cyc %0d: got %h expected %h", k, cyc, act_vec(k), exp_vec(k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_req();
        test_ptr_wrap();
        test_timeout();
        test_data_sweep();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 8:1 data mux between eight requesters. It grants the mux to one requester at a time, drives the 3-bit mux select, and gates the routed bit with a valid qualifier. It enforces a per-grant hold limit so no requester can starve the others. It sits between the requester logic and the 8:1 mux datapath; the mux is implemented inside the block as `data_o`.

Parameters:
MAX_HOLD, 16, maximum consecutive cycles a single grant may last; legal range 1..255.
HOLD_W, 8, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
clk     input   1  single clock; all state updates on the rising edge
rst_n   input   1  asynchronous, active-low reset
req     input   8  request vector; bit i = requester i wants the mux
done    input   1  current grant holder has finished; sampled only while valid=1
data_i  input   8  mux data inputs; bit i belongs to requester i
grant   output  8  one-hot grant, registered; all zeros when idle
sel     output  3  registered mux select (index of the granted requester)
valid   output  1  registered; 1 while a grant is active
timeout output  1  registered one-cycle pulse: a grant was ended by the hold limit
data_o  output  1  combinational: data_i[sel] when valid=1, else 0

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, grant=0, sel=0, valid=0, timeout=0, ptr=7, hold_cnt=0.
- Reset takes effect immediately, including mid-grant. No completion or timeout is reported for a grant cut off by reset.
- Winner selection: scan req in order ptr+1, ptr+2, … ptr+8 (mod 8); the first set bit wins.
  - Because ptr itself is scanned last, the last holder can win again only if it is the sole requester.
- State IDLE:
  - valid=0, grant=0; sel holds its last value.
  - If |req at a clock edge, then on that edge: state=GRANT, grant=onehot(winner), sel=winner, valid=1, hold_cnt=0.
  - Latency is one cycle from req sampled high to grant visible.
- State GRANT: hold_cnt increments by 1 each cycle. The grant is released at an edge when any of these hold:
  - (a) done=1
  - (b) req[sel]=0 (requester withdrew)
  - (c) hold_cnt==MAX_HOLD-1
- On release:
  - ptr <= sel.
  - A new winner is computed from the current req using the updated ptr.
  - If a winner exists, go straight to GRANT with the new winner on the same edge (back-to-back, no idle bubble), with hold_cnt=0.
  - Otherwise go to IDLE, grant=0, valid=0.
- timeout=1 for exactly one cycle after a release caused only by (c).
  - If (c) coincides with (a) or (b), the release counts as normal and timeout=0.
- MAX_HOLD=1: every grant lasts exactly one cycle and timeout pulses on each release where done=0 and req[sel]=1.
- done while valid=0 is ignored.
- req changes of non-holders never affect the current grant.
- Invariants:
  - grant is one-hot or zero.
  - grant[sel]==valid.
  - No requester waits more than 7 grant periods once its req is high and held.

Decomposition:
- Package mux_arb_pkg holds: NUM_REQ=8, SEL_W=3, the state encoding (IDLE=1'b0, GRANT=1'b1), and a function onehot8(index).
- Sub-module rr_pick8 is purely combinational.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: found, idx[2:0].
  - It is instantiated once and used for both the IDLE and release decisions.
- The output mux uses a case on sel, gated by valid.

Test Plan:
1. Reset then req=8'h00 for 5 cycles -> grant=0, valid=0, sel=0, data_o=0 throughout; assert rst_n low mid-grant -> all outputs 0 immediately.
2. req=8'h01, done pulse after 3 cycles -> grant=8'h01 one cycle after req, sel=0; after done, re-grant of 0 back-to-back since it is the sole requester (hold_cnt restarts).
3. req=8'hFF held, done pulsed every 2nd cycle of each grant -> sel sequence 0,1,2,…,7,0 with no idle cycles; grant always one-hot.
4. req=8'h90 (bits 4,7), ptr=5 after a prior grant to 5 -> bit 7 granted first, then 4, then 7.
5. MAX_HOLD=4, req=8'h0C held, done=0 -> requester 2 holds 4 cycles, timeout pulses one cycle, requester 3 granted; done asserted on the 4th cycle -> no timeout pulse.
6. data_i=8'hA5 with a grant sweep -> data_o equals data_i[sel] (1,0,1,0,0,1,0,1) while valid=1 and 0 while idle; the bench checks data_o against a reference behavioural 8:1 mux.
